muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide engine in the EX stage, beside the single-cycle ALU. It accepts one operation at a time, stalls the pipeline while it computes, and returns a 32-bit result with a one-cycle done pulse. EX decode issues to it when funct7 is the M-extension value (0000001) on an R-type.

## Interface
- XLEN, 32: operand/result width; the iteration count equals XLEN.
- clock  in  1  system clock; every register updates on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  issue request; sampled only in IDLE.
- flush  in  1  synchronous kill of the in-flight operation (branch/trap).
- funct3  in  3  op select: MUL 000, MULH 001, MULHSU 010, MULHU 011, DIV 100, DIVU 101, REM 110, REMU 111.
- rs1  in  XLEN  operand A, dividend for divides.
- rs2  in  XLEN  operand B, divisor for divides.
- stall  out  1  combinational; holds IF/ID/EX.
- busy  out  1  registered; high in CALC, FIX and DONE.
- done  out  1  registered; one-cycle pulse in DONE.
- result  out  XLEN  registered; valid when done = 1, held until the next accepted start.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE, start = 1: latch funct3, operand magnitudes and sign flags.
  - Special case present: go to DONE, with the result written directly.
  - Otherwise: go to CALC, with count = 0.
- CALC: one iteration per cycle.
  - Multiply: shift-add on a 2·XLEN accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - After XLEN iterations, go to FIX.
- FIX: apply sign correction, select the low or high half or the quotient or remainder, write result, go to DONE.
- DONE: done = 1, then return to IDLE.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both operands unsigned.
- Sign of the result:
  - Product sign = sA XOR sB.
  - Quotient sign = sA XOR sB.
  - Remainder takes the dividend sign.
- Result selection:
  - MUL returns product[XLEN-1:0].
  - MULH/MULHSU/MULHU return product[2·XLEN-1:XLEN].
- Special cases, detected in IDLE (take the short path):
  - Divisor 0: DIV/DIVU return all-ones, REM/REMU return rs1.
  - Signed overflow (rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV returns 0x80000000, REM returns 0.
- stall = (state==IDLE & start & ~flush) | state==CALC | state==FIX. stall is 0 in DONE, so the pipeline advances and captures result in that cycle.
- start outside IDLE is ignored.
- flush in any state: next state IDLE, done stays 0, result is not updated. flush overrides a simultaneous start.
- reset: state IDLE, busy 0, done 0, result 0, count 0, accumulators 0. Reset mid-operation abandons the operation with no done pulse.

## Timing
- Cycle numbering: start accepted at edge E0.
- Normal operation:
  - CALC occupies cycles 1..XLEN.
  - FIX is at XLEN+1.
  - DONE is at XLEN+2 (34 for XLEN=32).
- Special-case operation: DONE at cycle 1.
- Back-to-back: a new start is accepted in the IDLE cycle after DONE. The minimum issue interval is XLEN+3 cycles.
- Iteration counter: width $clog2(XLEN)+1. Terminal compare is count == XLEN-1 in CALC.
- Arithmetic: magnitudes are XLEN-bit unsigned. Negating 0x80000000 yields 0x80000000, which is treated as unsigned 2^31. Divide partial remainder is XLEN+1 bits.

## Structure
- constants.vh gets FUNCT7_MULDIV and FUNCT3_MUL … FUNCT3_REMU, next to the existing FUNCT3 macros.
- FSM state encodings are local parameters, not shared.
- No sub-module; the shift datapath and FSM fit in one module of about 250 lines.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → result 0xFFFFFFEB; done at cycle 34; stall high in cycles 0..33.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF. Each takes 34 cycles.
- DIV/REM x / 0 → 0xFFFFFFFF / x. DIV 0x80000000 / −1 → 0x80000000, REM → 0. Each has done at cycle 1.
- flush at cycle 10 of a DIV → IDLE at cycle 11, no done pulse, result unchanged. A start with flush on the same cycle is not accepted.
- reset asserted mid-CALC, then a new MUL 3 × 5 → outputs zeroed after the reset edge; the new op returns 0x0000000F at cycle 34. A start held high while busy is ignored.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared opcode constants and decode helpers for the RV32M multiply/divide engine.
// Imported by the engine and by anything that issues to it.
`timescale 1ns/1ps
package muldiv_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  function automatic logic op_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // Remainder ops share bit 1 with the MULHSU/MULHU encodings, so qualify with bit 2.
  function automatic logic op_is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  function automatic logic op_signed_a(input logic [2:0] f3);
    case (f3)
      FUNCT3_MUL, FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_DIV, FUNCT3_REM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_signed_b(input logic [2:0] f3);
    case (f3)
      FUNCT3_MUL, FUNCT3_MULH, FUNCT3_DIV, FUNCT3_REM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: shift-add multiply and restoring divide
// on signed-magnitude operands, one bit per cycle, with sign fix-up at the end.
`timescale 1ns/1ps
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] op_q, op_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Operand decode in IDLE
  logic            sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_by_zero, div_overflow;
  logic [XLEN-1:0] special_val;

  assign sign_a = op_signed_a(funct3) & rs1[XLEN-1];
  assign sign_b = op_signed_b(funct3) & rs2[XLEN-1];
  assign mag_a  = sign_a ? -rs1 : rs1;
  assign mag_b  = sign_b ? -rs2 : rs2;

  assign div_by_zero  = op_is_div(funct3) && (rs2 == '0);
  assign div_overflow = ((funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM)) &&
                        (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2);

  always_comb begin
    special_val = '1;
    if (div_by_zero) begin
      special_val = op_is_rem(funct3) ? rs1 : '1;
    end else if (div_overflow) begin
      special_val = op_is_rem(funct3) ? '0 : rs1;
    end
  end

  // One shift-add multiply step: hi accumulates, lo holds the shrinking multiplier.
  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi_next, mul_lo_next;

  assign mul_sum     = {1'b0, hi_q} + {1'b0, (lo_q[0] ? op_q : '0)};
  assign mul_hi_next = mul_sum[XLEN:1];
  assign mul_lo_next = {mul_sum[0], lo_q[XLEN-1:1]};

  // One restoring divide step: hi is the partial remainder, lo shifts the dividend
  // out the top and the quotient in at the bottom.
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic            div_ge;
  logic [XLEN-1:0] div_hi_next, div_lo_next;

  assign div_shift   = {hi_q, lo_q[XLEN-1]};
  assign div_diff    = {1'b0, div_shift[XLEN-1:0]} - {1'b0, op_q};
  assign div_ge      = div_shift[XLEN] | ~div_diff[XLEN];
  assign div_hi_next = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_lo_next = {lo_q[XLEN-2:0], div_ge};

  // Sign correction and result selection
  logic [2*XLEN-1:0] product, prod_signed;
  logic [XLEN-1:0]   quot_signed, rem_signed;
  logic [XLEN-1:0]   fix_result;

  assign product     = {hi_q, lo_q};
  assign prod_signed = neg_q ? -product : product;
  assign quot_signed = neg_q ? -lo_q : lo_q;
  assign rem_signed  = rneg_q ? -hi_q : hi_q;

  always_comb begin
    fix_result = prod_signed[2*XLEN-1:XLEN];
    if (op_is_div(f3_q)) begin
      fix_result = op_is_rem(f3_q) ? rem_signed : quot_signed;
    end else if (f3_q == FUNCT3_MUL) begin
      fix_result = prod_signed[XLEN-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    f3_d     = f3_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    stall    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        stall = start & ~flush;
        if (start && !flush) begin
          f3_d   = funct3;
          neg_d  = sign_a ^ sign_b;
          rneg_d = sign_a;
          if (div_by_zero || div_overflow) begin
            result_d = special_val;
            state_d  = ST_DONE;
          end else begin
            count_d = '0;
            hi_d    = '0;
            lo_d    = op_is_div(funct3) ? mag_a : mag_b;
            op_d    = op_is_div(funct3) ? mag_b : mag_a;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        stall   = 1'b1;
        hi_d    = op_is_div(f3_q) ? div_hi_next : mul_hi_next;
        lo_d    = op_is_div(f3_q) ? div_lo_next : mul_lo_next;
        count_d = count_q + CW'(1);
        if (count_q == CW'(XLEN-1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        stall    = 1'b1;
        result_d = fix_result;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase

    // A kill leaves the last delivered result untouched.
    if (flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end
  end

  assign busy_d = (state_d != ST_IDLE);
  assign done_d = (state_d == ST_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      f3_q     <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      f3_q     <= f3_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
